// File: rtl/alu_seq_ctrl.sv
// Purpose: sequences OR/AND/XOR and multi-cycle 1-bit-per-cycle shifts through an external combinational ALU.
// Latency: accept-to-response is 2 cycles for logic ops, n+1 for an n-bit shift, 1 for a zero shift or an illegal op.
// Backpressure: one command in flight; req_ready is high only in IDLE, and the result is held in DONE until resp_ready.
module alu_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [6:0]  alu_ctrl,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_out,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [2:0] OP_OR  = 3'd0;
    localparam logic [2:0] OP_AND = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_SHL = 3'd3;
    localparam logic [2:0] OP_SHR = 3'd4;

    localparam logic [6:0] CTRL_OR   = 7'b0000000;
    localparam logic [6:0] CTRL_AND  = 7'b0000001;
    localparam logic [6:0] CTRL_XOR  = 7'b0000010;
    localparam logic [6:0] CTRL_SHL1 = 7'b0000101;
    localparam logic [6:0] CTRL_SHR1 = 7'b0000110;

    state_e      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic        err_q, err_d;

    // Shifts are realised as repeated single-bit ALU shifts, one per RUN cycle.
    function automatic logic [6:0] ctrl_of(input logic [2:0] op);
        logic [6:0] code;
        code = CTRL_OR;
        case (op)
            OP_OR:   code = CTRL_OR;
            OP_AND:  code = CTRL_AND;
            OP_XOR:  code = CTRL_XOR;
            OP_SHL:  code = CTRL_SHL1;
            OP_SHR:  code = CTRL_SHR1;
            default: code = CTRL_OR;
        endcase
        return code;
    endfunction

    // State and datapath registers; reset aborts any command in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= 32'd0;
            opnd_q  <= 32'd0;
            cnt_q   <= 5'd0;
            op_q    <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    // Next-state: accept in IDLE, fold ALU result into acc in RUN, wait for consumer in DONE.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    acc_d  = req_a;
                    opnd_d = req_b;
                    cnt_d  = req_b[4:0];
                    op_d   = req_op;
                    err_d  = 1'b0;
                    case (req_op)
                        OP_OR, OP_AND, OP_XOR: state_d = ST_RUN;
                        OP_SHL, OP_SHR: begin
                            // A zero-bit shift returns operand A untouched.
                            state_d = (req_b[4:0] == 5'd0) ? ST_DONE : ST_RUN;
                        end
                        default: begin
                            acc_d   = 32'd0;
                            err_d   = 1'b1;
                            state_d = ST_DONE;
                        end
                    endcase
                end
            end
            ST_RUN: begin
                acc_d = alu_out;
                if ((op_q == OP_SHL) || (op_q == OP_SHR)) begin
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state: ALU is driven only in RUN, result only in DONE.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_data  = 32'd0;
        resp_err   = 1'b0;
        alu_ctrl   = 7'b0000000;
        alu_a      = 32'd0;
        alu_b      = 32'd0;
        busy       = 1'b1;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_RUN: begin
                alu_ctrl = ctrl_of(op_q);
                alu_a    = acc_q;
                alu_b    = opnd_q;
            end
            ST_DONE: begin
                resp_valid = 1'b1;
                resp_data  = acc_q;
                resp_err   = err_q;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Purpose: self-checking bench for alu_seq_ctrl with a behavioural ALU and a result/latency reference model.
// Latency: checks accept-to-response cycle counts per command class.
// Backpressure: exercises resp_ready held low for several DONE cycles.
module tb_alu_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [6:0]  alu_ctrl;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_out;
    logic        busy;

    int n_chk;
    int n_fail;

    alu_seq_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .alu_ctrl   (alu_ctrl),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_out    (alu_out),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural combinational ALU; unknown opcodes yield a marker value.
    always_comb begin
        case (alu_ctrl)
            7'b0000000: alu_out = alu_a | alu_b;
            7'b0000001: alu_out = alu_a & alu_b;
            7'b0000010: alu_out = alu_a ^ alu_b;
            7'b0000101: alu_out = alu_a << 1;
            7'b0000110: alu_out = alu_a >> 1;
            default:    alu_out = 32'hDEAD_BEEF;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: whole-command results from plain arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] n;
        n = b[4:0];
        case (op)
            3'd0:    return a | b;
            3'd1:    return a & b;
            3'd2:    return a ^ b;
            3'd3:    return a << n;
            3'd4:    return a >> n;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] b);
        int n;
        n = int'(b[4:0]);
        if (op <= 3'd2) return 2;
        if (op == 3'd3 || op == 3'd4) return (n == 0) ? 1 : n + 1;
        return 1;
    endfunction

    function automatic logic [6:0] ref_code(input logic [2:0] op);
        case (op)
            3'd0:    return 7'b0000000;
            3'd1:    return 7'b0000001;
            3'd2:    return 7'b0000010;
            3'd3:    return 7'b0000101;
            3'd4:    return 7'b0000110;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_resp_data"}, resp_data, 0);
        chk({tag, "_resp_err"}, resp_err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_alu_ctrl"}, alu_ctrl, 0);
        chk({tag, "_alu_a"}, alu_a, 0);
        chk({tag, "_alu_b"}, alu_b, 0);
    endtask

    // Issue one command from a negedge in IDLE, follow it to completion, end at a negedge in IDLE.
    task automatic do_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] exp_d;
        int lat;
        exp_d = ref_result(op, a, b);
        chk("idle_req_ready", req_ready, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        @(negedge clk);
        lat = 1;
        while (lat <= 40) begin
            if (resp_valid) break;
            if (lat == 1) chk("run_alu_a", alu_a, a);
            chk("run_alu_ctrl", alu_ctrl, ref_code(op));
            chk("run_alu_b", alu_b, b);
            chk("run_busy", busy, 1);
            chk("run_req_ready", req_ready, 0);
            // Requests presented while busy must be ignored.
            req_op = 3'($urandom_range(7, 0));
            req_a  = $urandom;
            req_b  = $urandom;
            @(negedge clk);
            lat++;
        end
        req_valid = 1'b0;
        chk("latency", lat, ref_lat(op, b));
        chk("resp_data", resp_data, exp_d);
        chk("resp_err", resp_err, (op > 3'd4) ? 1 : 0);
        chk("done_busy", busy, 1);
        chk("done_req_ready", req_ready, 0);
        chk("done_alu_ctrl", alu_ctrl, 0);
        chk("done_alu_a", alu_a, 0);
        chk("done_alu_b", alu_b, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", resp_valid, 1);
            chk("hold_data", resp_data, exp_d);
            chk("hold_req_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("post_resp_valid", resp_valid, 0);
        chk("post_req_ready", req_ready, 1);
        chk("post_busy", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        n_chk      = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 3'd0;
        req_a      = 32'd0;
        req_b      = 32'd0;
        resp_ready = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors.
        do_cmd(3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
        do_cmd(3'd3, 32'h0000_0001, 32'd4, 0);
        do_cmd(3'd4, 32'h8000_0000, 32'd31, 0);
        do_cmd(3'd4, 32'h8000_0000, 32'd0, 0);
        do_cmd(3'd6, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        do_cmd(3'd0, 32'h0F0F_0000, 32'h0000_F0F0, 5);
        do_cmd(3'd1, 32'hFFFF_0000, 32'h0F0F_0F0F, 1);
        do_cmd(3'd3, 32'hFFFF_FFFF, 32'd31, 2);

        // Reset asserted in the third RUN cycle of a 20-bit shift.
        req_valid = 1'b1;
        req_op    = 3'd3;
        req_a     = 32'h0000_0003;
        req_b     = 32'd20;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        repeat (2) begin
            @(negedge clk);
            lat++;
        end
        chk("midrun_busy", busy, 1);
        chk("midrun_alu_ctrl", alu_ctrl, 7'b0000101);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_rst");
        @(negedge clk);
        check_reset_outputs("midrun_rst_hold");
        rst_n = 1'b1;
        do_cmd(3'd2, 32'hAAAA_5555, 32'h0F0F_F0F0, 0);

        // Reset while a result waits in DONE.
        req_valid = 1'b1;
        req_op    = 3'd7;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("done_before_rst", resp_valid, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("done_rst");
        @(negedge clk);
        rst_n = 1'b1;
        do_cmd(3'd4, 32'hC000_0000, 32'd3, 0);

        // Randomized commands.
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(7, 0));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(3, 0) == 0) b[4:0] = 5'd0;
            do_cmd(op, a, b, int'($urandom_range(3, 0)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
